// File: rtl/keccak_rate_packer.sv
// Packs a byte-stream message into rate-sized blocks of 64-bit lanes, applies
// pad10*1 with a domain byte and hands blocks to the absorb stage via valid/ready.
module keccak_rate_packer #(
  parameter int unsigned RATE_BYTES = 136,
  parameter int unsigned IN_BYTES   = 8,
  parameter logic [7:0]  DOMAIN     = 8'h1F,
  parameter int unsigned LANE_BE    = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [8*IN_BYTES-1:0]               in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [$clog2(IN_BYTES+1)-1:0]       in_nbytes,
  output logic                                in_ready,
  output logic [8*RATE_BYTES-1:0]             blk_lanes,
  output logic                                blk_valid,
  output logic                                blk_final,
  input  logic                                blk_ready
);

  localparam int unsigned BW    = 8 * RATE_BYTES;
  localparam int unsigned LANES = RATE_BYTES / 8;
  localparam int unsigned CW    = $clog2(RATE_BYTES + 1);

  localparam logic [1:0] FILL       = 2'd0;
  localparam logic [1:0] HOLD       = 2'd1;
  localparam logic [1:0] HOLD_EXTRA = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] buf_q, buf_d;
  logic          final_q, final_d;
  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  int unsigned   n_bytes;
  int unsigned   pos;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      final_q <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      final_q <= final_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state, byte packing and padding
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    final_d = final_q;
    pend_d  = pend_q;
    n_bytes = IN_BYTES;
    pos     = 0;
    case (state_q)
      FILL: begin
        if (in_valid && ready_q) begin
          if (in_last && (32'(in_nbytes) < IN_BYTES)) n_bytes = 32'(in_nbytes);
          for (int unsigned k = 0; k < IN_BYTES; k++) begin
            if (k < n_bytes) buf_d[8*(32'(cnt_q)+k) +: 8] = in_data[8*k +: 8];
          end
          pos = 32'(cnt_q) + n_bytes;
          if (!in_last) begin
            cnt_d = cnt_q + CW'(IN_BYTES);
            if (cnt_d == CW'(RATE_BYTES)) begin
              cnt_d   = '0;
              final_d = 1'b0;
              state_d = HOLD;
            end
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
            if (pos < RATE_BYTES) begin
              // Domain byte first so that p = RATE-1 merges into DOMAIN|0x80
              buf_d[8*pos +: 8]  = DOMAIN;
              buf_d[BW-1 -: 8]   = buf_d[BW-1 -: 8] | 8'h80;
              final_d            = 1'b1;
            end else begin
              final_d = 1'b0;
              pend_d  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (blk_ready) begin
          buf_d = '0;
          cnt_d = '0;
          if (pend_q) begin
            buf_d[7:0]       = DOMAIN;
            buf_d[BW-1 -: 8] = 8'h80;
            final_d          = 1'b1;
            state_d          = HOLD_EXTRA;
          end else begin
            final_d = 1'b0;
            state_d = FILL;
          end
        end
      end
      HOLD_EXTRA: begin
        if (blk_ready) begin
          buf_d   = '0;
          pend_d  = 1'b0;
          final_d = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    valid_d = (state_d != FILL);
    ready_d = (state_d == FILL);
  end

  // Lane byte order is pure wiring off the buffer register
  always_comb begin
    blk_lanes = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        blk_lanes[64*i + 8*j +: 8] = buf_q[8*(8*i + ((LANE_BE != 0) ? (7 - j) : j)) +: 8];
      end
    end
  end

  assign in_ready  = ready_q & ~rst;
  assign blk_valid = valid_q;
  assign blk_final = final_q;

endmodule

// File: tb/tb_keccak_rate_packer.sv
// Directed bench for keccak_rate_packer: little- and big-endian lane instances
// share stimulus; expected blocks are queued at drive time and popped on output.
`timescale 1ns/1ps
module tb_keccak_rate_packer;

  localparam int unsigned RB  = 136;
  localparam int unsigned IB  = 8;
  localparam int unsigned BW  = 8 * RB;
  localparam int unsigned DW  = 8 * IB;
  localparam int unsigned NBW = $clog2(IB + 1);
  localparam int unsigned LN  = RB / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_last;
  logic [NBW-1:0] in_nbytes;
  logic           blk_ready;
  logic           in_ready, in_ready_be;
  logic [BW-1:0]  blk_lanes, blk_lanes_be;
  logic           blk_valid, blk_valid_be;
  logic           blk_final, blk_final_be;

  always #5 clk = ~clk;

  keccak_rate_packer #(.RATE_BYTES(RB), .IN_BYTES(IB), .DOMAIN(8'h1F), .LANE_BE(0)) u_le (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_ready(in_ready), .blk_lanes(blk_lanes),
    .blk_valid(blk_valid), .blk_final(blk_final), .blk_ready(blk_ready));

  keccak_rate_packer #(.RATE_BYTES(RB), .IN_BYTES(IB), .DOMAIN(8'h1F), .LANE_BE(1)) u_be (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_ready(in_ready_be), .blk_lanes(blk_lanes_be),
    .blk_valid(blk_valid_be), .blk_final(blk_final_be), .blk_ready(blk_ready));

  typedef struct packed {
    logic [BW-1:0] le;
    logic [BW-1:0] be;
    logic          fin;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  msg [RB];
  exp_t        sb [$];

  // Reference block: message bytes, optional pad10*1, then lane byte order
  function automatic logic [BW-1:0] model(int unsigned nmsg, bit pad, bit be);
    logic [7:0]    b [RB];
    logic [BW-1:0] r;
    for (int unsigned i = 0; i < RB; i++) b[i] = (i < nmsg) ? msg[i] : 8'h00;
    if (pad) begin
      b[nmsg]  = 8'h1F;
      b[RB-1]  = b[RB-1] | 8'h80;
    end
    for (int unsigned i = 0; i < LN; i++)
      for (int unsigned j = 0; j < 8; j++)
        r[64*i + 8*j +: 8] = be ? b[8*i + 7 - j] : b[8*i + j];
    return r;
  endfunction

  function automatic logic [DW-1:0] beat(int unsigned off);
    logic [DW-1:0] d;
    for (int unsigned k = 0; k < IB; k++) d[8*k +: 8] = msg[off + k];
    return d;
  endfunction

  task automatic push_exp(int unsigned nmsg, bit pad, bit fin);
    sb.push_back(exp_t'{le: model(nmsg, pad, 1'b0), be: model(nmsg, pad, 1'b1), fin: fin});
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
    int first = -1;
    for (int i = 0; i < int'(LN); i++)
      if ((obs[64*i +: 64] !== exp[64*i +: 64]) && first < 0) first = i;
    if (first < 0) first = 0;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s lane%0d observed=%h expected=%h", tag, first,
             obs[64*first +: 64], exp[64*first +: 64]);
    end
  endtask

  task automatic send(logic [DW-1:0] d, bit last, logic [NBW-1:0] nb);
    int w = 0;
    in_data = d; in_valid = 1'b1; in_last = last; in_nbytes = nb;
    @(negedge clk);
    while (!in_ready && w < 50) begin w++; @(negedge clk); end
    checks++;
    assert (w < 50) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected<50", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_blk();
    int w = 0;
    while (!blk_valid && w < 50) begin @(posedge clk); #1; w++; end
    checks++;
    assert (w < 50) else begin
      failures++;
      $error("FAIL blk_timeout observed=%0d expected<50", w);
    end
  endtask

  task automatic check_blk(string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb_empty observed=%0d expected>0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_w({tag, "_le"}, blk_lanes, e.le);
      chk_w({tag, "_be"}, blk_lanes_be, e.be);
      chk({tag, "_final"}, 64'(blk_final), 64'(e.fin));
      chk({tag, "_final_be"}, 64'(blk_final_be), 64'(e.fin));
      chk({tag, "_valid_be"}, 64'(blk_valid_be), 64'd1);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    end
  endtask

  task automatic handshake();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic run_abc(string tag);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    push_exp(3, 1'b1, 1'b1);
    send(64'h0000000000636261, 1'b1, NBW'(3));
    wait_blk();
    check_blk(tag);
    chk({tag, "_lane0"}, blk_lanes[63:0], 64'h000000001F636261);
    chk({tag, "_lane16"}, blk_lanes[64*16 +: 64], 64'h8000000000000000);
    chk({tag, "_be_lane0"}, blk_lanes_be[63:0], 64'h6162631F00000000);
    chk({tag, "_be_lane16"}, blk_lanes_be[64*16 +: 64], 64'h0000000000000080);
    handshake();
  endtask

  initial begin
    int vcount;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0; blk_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_in_ready_be", 64'(in_ready_be), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_final", 64'(blk_final), 64'd0);
    chk_w("rst_lanes", blk_lanes, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Empty message
    push_exp(0, 1'b1, 1'b1);
    send('0, 1'b1, NBW'(0));
    wait_blk();
    check_blk("empty");
    chk("empty_lane0", blk_lanes[63:0], 64'h000000000000001F);
    chk("empty_lane16", blk_lanes[64*16 +: 64], 64'h8000000000000000);
    handshake();

    run_abc("abc");

    // Out-of-range nbytes clamps to a full beat
    for (int unsigned i = 0; i < 8; i++) msg[i] = 8'(i + 1);
    push_exp(8, 1'b1, 1'b1);
    send(beat(0), 1'b1, NBW'(15));
    wait_blk();
    check_blk("clamp");
    chk("clamp_lane0", blk_lanes[63:0], 64'h0807060504030201);
    chk("clamp_lane1", blk_lanes[127:64], 64'h000000000000001F);
    handshake();

    // 135 bytes: pad merges into the final byte
    for (int unsigned i = 0; i < RB; i++) msg[i] = 8'hAA;
    push_exp(135, 1'b1, 1'b1);
    for (int unsigned b = 0; b < 16; b++) send(beat(8*b), 1'b0, '0);
    send(beat(128), 1'b1, NBW'(7));
    wait_blk();
    check_blk("m135");
    chk("m135_lane16", blk_lanes[64*16 +: 64], 64'h9FAAAAAAAAAAAAAA);
    handshake();
    chk("m135_in_ready_after", 64'(in_ready), 64'd1);

    // 136 bytes: full data block, then a pad-only block
    for (int unsigned i = 0; i < RB; i++) msg[i] = 8'(i);
    push_exp(136, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b1);
    for (int unsigned b = 0; b < 16; b++) send(beat(8*b), 1'b0, '0);
    send(beat(128), 1'b1, NBW'(8));
    wait_blk();
    check_blk("m136_data");
    handshake();
    chk("m136_valid_mid", 64'(blk_valid), 64'd1);
    check_blk("m136_pad");
    chk("m136_pad_lane0", blk_lanes[63:0], 64'h000000000000001F);
    chk("m136_pad_lane16", blk_lanes[64*16 +: 64], 64'h8000000000000000);
    handshake();
    chk("m136_in_ready_after", 64'(in_ready), 64'd1);

    // Backpressure: outputs hold, offered beat is not consumed
    for (int unsigned i = 0; i < 16; i++) msg[i] = 8'(8'h30 + i);
    push_exp(16, 1'b1, 1'b1);
    send(beat(0), 1'b0, '0);
    send(beat(8), 1'b1, NBW'(8));
    wait_blk();
    in_data = '1; in_valid = 1'b1; in_last = 1'b1; in_nbytes = NBW'(8);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk_w($sformatf("bp_stable%0d", c), blk_lanes, sb[0].le);
      chk($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check_blk("bp");
    handshake();
    msg[0] = 8'h11; msg[1] = 8'h22;
    push_exp(2, 1'b1, 1'b1);
    send(64'hFFFFFFFFFFFF2211, 1'b1, NBW'(2));
    wait_blk();
    check_blk("bp_next");
    handshake();

    // Reset mid-fill drops the partial block
    for (int unsigned i = 0; i < 40; i++) msg[i] = 8'h5A;
    for (int unsigned b = 0; b < 5; b++) send(beat(8*b), 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(blk_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (blk_valid) vcount++;
    end
    chk("midrst_no_block", 64'(vcount), 64'd0);
    run_abc("abc_after_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keccak_rate_packer.md
Name: keccak_rate_packer

Overview:
- Sequential, parametrised front-end for the SHAKE/Keccak sponge.
- Accepts a byte-stream message in fixed-width beats and packs it into rate-sized blocks of 64-bit lanes.
- Applies domain-separation padding (pad10*1) and hands each complete block to the absorb stage over a valid/ready handshake.
- Generalises the fixed, combinational 1600-bit-to-lane byte mapping to any rate, any beat width and either lane byte order, and adds buffering, padding and flow control.

Parameters:
- RATE_BYTES, 136, sponge rate in bytes (136 = SHAKE256); must be a multiple of 8 and of IN_BYTES.
- IN_BYTES, 8, input beat width in bytes.
- DOMAIN, 8'h1F, domain/padding-start byte (8'h1F for SHAKE, 8'h06 for SHA3).
- LANE_BE, 0, lane byte order: 0 = message byte 8i+j in lane i bits [8j+7:8j] (FIPS-202 little-endian); 1 = byte-swapped, so message byte 8i sits in lane i bits [63:56].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8*IN_BYTES  message beat; byte k = in_data[8k+7:8k], which is the k-th next message byte.
- in_valid  in  1  beat valid.
- in_last  in  1  beat is the final beat of the message.
- in_nbytes  in  $clog2(IN_BYTES+1)  valid bytes on the last beat (0..IN_BYTES); ignored when in_last=0.
- in_ready  out  1  packer can accept a beat.
- blk_lanes  out  8*RATE_BYTES  packed block; lane i = blk_lanes[64i+63:64i].
- blk_valid  out  1  block available.
- blk_final  out  1  block carries the padding (last block of the message).
- blk_ready  in  1  absorb stage accepts the block.

Behaviour:
- **Reset** (async, active-high): state=FILL, byte count=0, buffer all zero, blk_valid=0, blk_final=0. in_ready is forced 0 while rst=1.
- **States:** FILL, HOLD, HOLD_EXTRA.
  - in_ready=1 only in FILL.
  - blk_valid=1 in HOLD and HOLD_EXTRA.
- **FILL, accepted beat** (in_valid & in_ready): bytes are written at offsets cnt..cnt+n-1.
  - n = IN_BYTES on non-last beats.
  - n = min(in_nbytes, IN_BYTES) on the last beat; out-of-range in_nbytes is clamped.
  - Bytes above n are discarded; unwritten buffer bytes stay zero.
- **Non-last beat:**
  - cnt += IN_BYTES.
  - If cnt reaches RATE_BYTES: go to HOLD with blk_final=0 and cnt=0.
- **Last beat**, with p = cnt + n:
  - p < RATE_BYTES: byte[p] = DOMAIN, byte[RATE_BYTES-1] |= 8'h80. If p = RATE_BYTES-1, that byte is DOMAIN|8'h80 (8'h9F for SHAKE). Go to HOLD with blk_final=1.
  - p = RATE_BYTES: the block holds message data only. Go to HOLD with blk_final=0 and set a pending-pad flag.
- **HOLD:** blk_lanes and blk_final are registered and stable until blk_ready.
  - On blk_valid & blk_ready: clear the buffer and cnt.
  - If pending-pad is set: load a pad-only block (byte0 = DOMAIN, byte[RATE_BYTES-1] = 8'h80, blk_final=1) and go to HOLD_EXTRA.
  - Otherwise go to FILL.
- **HOLD_EXTRA:** on blk_ready, clear the flag and buffer and return to FILL.
- **Latency:** blk_valid rises the cycle after the beat that completes a block.
  - No beat is accepted in the same cycle a block is handed off; in_ready rises the cycle after the handshake.
  - Sustained throughput is RATE_BYTES/IN_BYTES + 1 cycles per block.
- **Empty message:** a single beat with in_last=1 and in_nbytes=0 at cnt=0 yields one pad-only block with blk_final=1.
- **Stalled inputs:** in_valid and in_data are ignored when in_ready=0. A stalled blk_ready holds all outputs indefinitely.
- **Reset mid-operation:** any partial block or held block is dropped; nothing is emitted.
- **Lane layout:** with LANE_BE=0, lane i bits [8j+7:8j] = buffer byte 8i+j. LANE_BE=1 reverses the bytes within each lane.

Test Plan:
- **Empty message** (defaults): one beat, in_last=1, in_nbytes=0 -> one block, blk_final=1, lane0=64'h000000000000001F, lane16=64'h8000000000000000, all other lanes 0.
- **"abc"**: in_data low bytes 61 62 63, in_last=1, in_nbytes=3 -> lane0=64'h000000001F636261, lane16=64'h8000000000000000. With LANE_BE=1 -> lane0=64'h6162631F00000000, lane16=64'h0000000000000080.
- **135-byte message** (16 full beats + last beat with nbytes=7, all bytes 8'hAA) -> one block, blk_final=1, byte135=8'h9F, lane16=64'h9FAAAAAAAAAAAAAA.
- **136-byte message** (17 beats, last nbytes=8) -> block 1 contains the data with blk_final=0; then a pad-only block with lane0=64'h1F, lane16=64'h80<<56 and blk_final=1. in_ready stays 0 until the second handshake.
- **Backpressure:** hold blk_ready=0 for 5 cycles after blk_valid -> blk_lanes stable, in_ready=0, no beat consumed. A second message accepted afterwards packs from byte 0 with a clean buffer.
- **Reset mid-fill:** assert rst after 5 accepted beats -> blk_valid=0 immediately, no block emitted. The next "abc" message produces exactly the "abc" block above.
